// File: rtl/lc3b_memory_responder.sv
// lc3b_memory_responder
// Memory-side responder for the LC-3b memory data path. A request is
// captured when the responder is idle. After a fixed latency, a word or
// byte access is performed on an internal 16-bit word array, and R pulses
// for one cycle.
//
// Parameters
//   ADDR_WIDTH : word-address bits; the array holds 2^ADDR_WIDTH words,
//                indexed by MAR[ADDR_WIDTH:1] (ADDR_WIDTH < 15)
//   LATENCY    : cycles from the request cycle to the R cycle (2..15)
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   MIO_EN     in   access request, held by the CPU until it sees R
//   R_W        in   1 = write, 0 = read
//   DATA_SIZE  in   0 = byte, 1 = word
//   MAR        in   byte address
//   MDR        in   lane-aligned write data
//   mem_data   out  full word from the last completed read
//   R          out  ready, one-cycle pulse per completed access
//
// state | meaning
// IDLE  | waiting for MIO_EN; request fields are captured here only
// BUSY  | latency count running; MIO_EN low aborts without a write
// DONE  | access performed on entry; R high for this cycle
// HOLD  | request still held after R; wait for MIO_EN to drop
module lc3b_memory_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic        DATA_SIZE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    output logic [15:0] mem_data,
    output logic        R
);

    localparam logic       DATA_WORD = 1'b1;
    localparam logic [3:0] CNT_LAST  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rw_q, rw_d;
    logic                  size_q, size_d;
    logic [ADDR_WIDTH:0]   mar_q, mar_d;
    logic [15:0]           mdr_q, mdr_d;
    logic [15:0]           mem_data_q, mem_data_d;
    logic                  r_q, r_d;
    logic                  commit;

    logic [15:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;

    // MAR bits above the word index alias and are deliberately dropped.
    logic unused_mar_hi;
    assign unused_mar_hi = ^MAR[15:ADDR_WIDTH+1];

    assign idx = mar_q[ADDR_WIDTH:1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        size_d     = size_q;
        mar_d      = mar_q;
        mdr_d      = mdr_q;
        mem_data_d = mem_data_q;
        r_d        = 1'b0;
        commit     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MIO_EN) begin
                    rw_d    = R_W;
                    size_d  = DATA_SIZE;
                    mar_d   = MAR[ADDR_WIDTH:0];
                    mdr_d   = MDR;
                    cnt_d   = 4'd1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!MIO_EN) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        commit  = 1'b1;
                        r_d     = 1'b1;
                        state_d = S_DONE;
                        if (!rw_q) begin
                            mem_data_d = mem[idx];
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = MIO_EN ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!MIO_EN) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rw_q       <= 1'b0;
            size_q     <= 1'b0;
            mar_q      <= '0;
            mdr_q      <= 16'h0000;
            mem_data_q <= 16'h0000;
            r_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            size_q     <= size_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            mem_data_q <= mem_data_d;
            r_q        <= r_d;
        end
    end

    // The array is not cleared by reset; reset still blocks a commit that
    // lands on the same edge.
    always_ff @(posedge clk) begin
        if (commit && rw_q && !reset) begin
            if (size_q == DATA_WORD) begin
                mem[idx] <= mdr_q;
            end else if (mar_q[0]) begin
                mem[idx][15:8] <= mdr_q[15:8];
            end else begin
                mem[idx][7:0] <= mdr_q[7:0];
            end
        end
    end

    assign mem_data = mem_data_q;
    assign R        = r_q;

endmodule

// File: tb/tb_lc3b_memory_responder.sv
module tb_lc3b_memory_responder;

    localparam int AW  = 10;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        MIO_EN, R_W, DATA_SIZE;
    logic [15:0] MAR, MDR;
    logic [15:0] mem_data;
    logic        R;

    logic        mio2, rw2, size2;
    logic [15:0] mar2, mdr2, md2;
    logic        r2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit check_en = 0;

    typedef struct {
        int          c;
        logic [15:0] v;
    } upd_t;

    upd_t        md_pend[$];
    int          r_cycles[$];
    logic [15:0] md_exp;
    logic [15:0] model_mem [int];

    lc3b_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .MIO_EN(MIO_EN), .R_W(R_W),
        .DATA_SIZE(DATA_SIZE), .MAR(MAR), .MDR(MDR),
        .mem_data(mem_data), .R(R)
    );

    lc3b_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .MIO_EN(mio2), .R_W(rw2),
        .DATA_SIZE(size2), .MAR(mar2), .MDR(mdr2),
        .mem_data(md2), .R(r2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int widx(input logic [15:0] a);
        return (int'(a) >> 1) & ((1 << AW) - 1);
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (model_mem.exists(widx(a))) return model_mem[widx(a)];
        return 16'hxxxx;
    endfunction

    task automatic model_write(input logic sz, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] w;
        w = model_read(a);
        if (sz) w = d;
        else if (a[0]) w = (w & 16'h00FF) | (d & 16'hFF00);
        else w = (w & 16'hFF00) | (d & 16'h00FF);
        model_mem[widx(a)] = w;
    endtask

    // Every-cycle comparison of the responder against the transaction model.
    always @(negedge clk) begin
        if (check_en) begin
            logic exp_r;
            while (md_pend.size() > 0 && md_pend[0].c <= cyc) begin
                md_exp = md_pend[0].v;
                void'(md_pend.pop_front());
            end
            exp_r = 1'b0;
            if (r_cycles.size() > 0 && r_cycles[0] == cyc) begin
                exp_r = 1'b1;
                void'(r_cycles.pop_front());
            end
            chk("r_pulse", {15'b0, R}, {15'b0, exp_r});
            chk("mem_data", mem_data, md_exp);
        end
    end

    // One request from the IDLE cycle. hold = extra cycles MIO_EN stays high
    // after the R cycle; abort_at/rst_at = cycle offset to drop MIO_EN or
    // assert reset (0 = not used).
    task automatic access(input logic rw, input logic sz, input logic [15:0] a,
                          input logic [15:0] d, input int hold, input int abort_at,
                          input int rst_at, input bit scramble);
        int c0, end_c;
        @(posedge clk); #1;
        MIO_EN = 1'b1; R_W = rw; DATA_SIZE = sz; MAR = a; MDR = d;
        c0 = cyc;
        if (abort_at == 0 && rst_at == 0) begin
            r_cycles.push_back(c0 + LAT);
            if (rw) model_write(sz, a, d);
            else md_pend.push_back('{c0 + LAT, model_read(a)});
        end
        if (rst_at != 0) md_pend.push_back('{c0 + rst_at + 1, 16'h0000});
        end_c = (abort_at != 0) ? c0 + abort_at :
                (rst_at != 0)   ? c0 + rst_at : c0 + LAT + hold;
        while (cyc < end_c) begin
            @(posedge clk); #1;
            if (scramble) begin
                MAR = 16'($urandom); MDR = 16'($urandom);
                R_W = ~R_W; DATA_SIZE = ~DATA_SIZE;
            end
        end
        if (rst_at != 0) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset  = 1'b0;
            MIO_EN = 1'b0;
        end else begin
            MIO_EN = 1'b0;
        end
    endtask

    task automatic lat2_access(input logic rw, input logic [15:0] a, input logic [15:0] d,
                               input logic [15:0] exp_md);
        int c0;
        @(posedge clk); #1;
        mio2 = 1'b1; rw2 = rw; size2 = 1'b1; mar2 = a; mdr2 = d;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lat2_r", {15'b0, r2}, {15'b0, (cyc == c0 + 2)});
            if (cyc == c0 + 2) begin
                if (!rw) chk("lat2_data", md2, exp_md);
                mio2 = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        MIO_EN = 1'b0; R_W = 1'b0; DATA_SIZE = 1'b1; MAR = 16'h0; MDR = 16'h0;
        mio2 = 1'b0; rw2 = 1'b0; size2 = 1'b1; mar2 = 16'h0; mdr2 = 16'h0;
        md_exp = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_en = 1'b1;
        repeat (5) @(posedge clk);

        // word write with held request, then aliased word read
        access(1'b1, 1'b1, 16'h0010, 16'h1234, 2, 0, 0, 0);
        access(1'b0, 1'b1, 16'h0011, 16'h0000, 0, 0, 0, 0);
        chk("lit_word_read", mem_data, 16'h1234);

        // byte lanes
        access(1'b1, 1'b1, 16'h0020, 16'h0000, 0, 0, 0, 0);
        access(1'b1, 1'b0, 16'h0020, 16'h00AB, 0, 0, 0, 0);
        access(1'b1, 1'b0, 16'h0021, 16'hCD00, 1, 0, 0, 0);
        access(1'b0, 1'b1, 16'h0020, 16'h0000, 0, 0, 0, 0);
        chk("lit_byte_merge", mem_data, 16'hCDAB);
        access(1'b0, 1'b0, 16'h0021, 16'h0000, 0, 0, 0, 0);
        chk("lit_byte_read_full", mem_data, 16'hCDAB);

        // abort by MIO_EN drop, then by reset on the commit edge
        access(1'b1, 1'b1, 16'h0030, 16'h1111, 0, 0, 0, 0);
        access(1'b1, 1'b1, 16'h0030, 16'h5555, 0, 2, 0, 0);
        access(1'b0, 1'b1, 16'h0030, 16'h0000, 0, 0, 0, 0);
        chk("lit_abort_read", mem_data, 16'h1111);
        access(1'b1, 1'b1, 16'h0030, 16'h5555, 0, 0, 4, 0);
        chk("lit_reset_md", mem_data, 16'h0000);
        access(1'b0, 1'b1, 16'h0030, 16'h0000, 0, 0, 0, 0);
        chk("lit_reset_read", mem_data, 16'h1111);

        // inputs changing during BUSY are ignored
        access(1'b1, 1'b1, 16'h0040, 16'hA5A5, 1, 0, 0, 1);
        access(1'b0, 1'b1, 16'h0040, 16'h0000, 0, 0, 0, 1);
        chk("lit_scramble_read", mem_data, 16'hA5A5);

        // high address bits alias
        access(1'b1, 1'b1, 16'h0802, 16'h7E57, 0, 0, 0, 0);
        access(1'b0, 1'b1, 16'h0002, 16'h0000, 0, 0, 0, 0);
        chk("lit_alias_read", mem_data, 16'h7E57);

        // back-to-back: MIO_EN dropped in DONE, re-raised next cycle
        access(1'b0, 1'b1, 16'h0010, 16'h0000, 0, 0, 0, 0);
        chk("b2b_first_r", {15'b0, R}, 16'h0001);
        access(1'b0, 1'b0, 16'h0020, 16'h0000, 0, 0, 0, 0);
        chk("b2b_second_r", {15'b0, R}, 16'h0001);
        chk("lit_b2b_read", mem_data, 16'hCDAB);
        repeat (3) @(posedge clk);

        // LATENCY = 2 instance
        lat2_access(1'b1, 16'h0004, 16'hBEEF, 16'h0000);
        lat2_access(1'b0, 16'h0004, 16'h0000, 16'hBEEF);

        repeat (3) @(posedge clk);
        if (r_cycles.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL r_pending: %0d expected R pulses not reached", r_cycles.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3b_memory_responder.md
# lc3b_memory_responder

Memory-side responder for the LC-3b memory data path. It accepts the CPU's memory requests (MIO_EN, R_W, DATA_SIZE, MAR, aligned MDR contents) and performs the word or byte access on an internal word array after a fixed multi-cycle latency. It signals completion on R, which the microsequencer polls. It also returns read data to the MDR input mux, which performs low-byte extraction itself.

## Interface
- ADDR_WIDTH, default 10: word-address bits; the array holds 2^ADDR_WIDTH 16-bit words, indexed by MAR[ADDR_WIDTH:1].
- LATENCY, default 5: cycles from the request cycle to the R cycle; legal range 2..15.
- DATA_BYTE = 0, DATA_WORD = 1: encodings of DATA_SIZE.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MIO_EN  in  1  memory access request; held high by the CPU until it observes R.
- R_W  in  1  1 = write, 0 = read.
- DATA_SIZE  in  1  DATA_BYTE or DATA_WORD.
- MAR  in  16  byte address.
- MDR  in  16  write data, already lane-aligned by the MDR: a byte at an odd address sits in [15:8], a byte at an even address sits in [7:0].
- mem_data  out  16  full read word to the MDR input mux.
- R  out  1  ready; high for exactly one cycle per completed access.

## Operation
- FSM states:
  - IDLE: R=0. If MIO_EN=1, latch R_W, DATA_SIZE, MAR, MDR, load counter=1, go to BUSY.
  - BUSY: if MIO_EN=0, abort to IDLE with no array write. Otherwise increment the counter. When counter == LATENCY-1, perform the access at that edge and go to DONE.
  - DONE: R=1 for this single cycle. Next state is HOLD if MIO_EN=1, otherwise IDLE.
  - HOLD: R=0. Stay until MIO_EN=0, then go to IDLE. This stops one held request from being serviced twice.
- Request inputs are sampled only in IDLE; changes during BUSY, DONE and HOLD are ignored.
- Address mapping:
  - Word index = latched MAR[ADDR_WIDTH:1]; higher MAR bits are ignored, so addresses alias.
  - For word accesses MAR[0] is ignored.
- Read: mem_data <= array[index] (full word, both sizes). mem_data holds that value until the next completed read.
- Word write: array[index] <= latched MDR.
- Byte write:
  - MAR[0]=0 writes only [7:0] from MDR[7:0].
  - MAR[0]=1 writes only [15:8] from MDR[15:8].
  - The other byte lane is unchanged.
- A write leaves mem_data unchanged.
- Reset:
  - FSM goes to IDLE, counter=0, R=0, mem_data=16'h0000.
  - The array is not cleared.
  - Reset during BUSY cancels the access; no write occurs.
  - If reset coincides with the commit edge, reset wins and no write occurs.

## Timing
- Cycle 0: IDLE with MIO_EN=1; the request is sampled at the end of cycle 0.
- Cycles 1..LATENCY-1: BUSY.
- Access edge: the end of cycle LATENCY-1.
- Cycle LATENCY: R=1, and for reads mem_data is valid.
- With LATENCY=5: request in cycle 0, R high in cycle 5.
- If MIO_EN falls after DONE, the next request can be sampled 1 cycle after DONE (IDLE cycle). Minimum spacing between R pulses is LATENCY+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then idle: R=0, mem_data=0000 in every cycle, with MIO_EN=0.
- Word write then word read:
  - Write MAR=0x0010, MDR=0x1234, DATA_WORD.
  - R pulses in cycle 5 only, then stays 0 in HOLD while MIO_EN is held 2 more cycles.
  - Reading MAR=0x0011 (word) returns mem_data=0x1234 with R in cycle 5.
- Byte writes:
  - Start with word 0x0020 = 0x0000.
  - Byte write MAR=0x0020, MDR=0x00AB, then byte write MAR=0x0021, MDR=0xCD00.
  - A word read of MAR=0x0020 returns 0xCDAB.
  - A byte read of MAR=0x0021 also returns the full word 0xCDAB.
- Abort:
  - Write request to 0x0030 with MDR=0x5555; drop MIO_EN in cycle 2.
  - R never asserts, and a subsequent read of 0x0030 returns the prior contents.
  - Repeat with reset asserted in cycle 4 instead: same result, and mem_data=0000 after reset.
- Input changes and aliasing:
  - Change MAR and MDR during BUSY; the access uses the cycle-0 values.
  - With ADDR_WIDTH=10, a write to 0x0802 is read back at 0x0002.
- Back-to-back requests and latency parameter:
  - Drop MIO_EN in the DONE cycle and raise it again next cycle; the second R comes exactly LATENCY+1 cycles after the first.
  - With LATENCY=2, R is high in cycle 2.
